core_mem_requester: RTL

//  Core-side initiator for the dual-core shared-memory arbiter; one instance per MIPS32 core.
//  - Accepts a single load/store from the core MEM stage and registers it.
//  - Drives req/addr/wdata/memread/memwrite toward the arbiter and waits for that core's grant.
//  - Captures read data on the grant cycle and stalls the pipeline until the access retires.

---
 rtl/core_mem_requester_if.sv | 26 ++
 rtl/core_mem_requester.sv | 73 +++++++
 2 files changed

// File: rtl/core_mem_requester_if.sv
// core_mem_requester_if: MEM-stage and arbiter-side signals of one core's memory requester
interface core_mem_requester_if;
    logic        mem_valid;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] load_data;
    logic        core_req;
    logic [31:0] core_addr;
    logic [31:0] core_wdata;
    logic        core_memwrite;
    logic        core_memread;
    logic        core_grant;
    logic [31:0] core_rdata;
    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, core_grant, core_rdata,
        input  stall, done, err, load_data, core_req, core_addr, core_wdata, core_memwrite, core_memread
    );
    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, core_grant, core_rdata,
        output stall, done, err, load_data, core_req, core_addr, core_wdata, core_memwrite, core_memread
    );
endinterface

// File: rtl/core_mem_requester.sv
// core_mem_requester: per-core initiator that registers one load/store and waits for the arbiter grant
// The arbiter-side bus is decoded from state so a lingering grant outside WAIT cannot repeat an access.
module core_mem_requester #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input logic                 clk,
    input logic                 rst,
    core_mem_requester_if.slave bus
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t      r_state;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_load_data;
    logic        r_we;
    logic        r_err;
    logic [15:0] r_cnt;
    logic        w_wait;
    logic        w_timeout;
    assign w_wait    = r_state == WAIT;
    assign w_timeout = TIMEOUT_CYCLES != 0 && int'({16'd0, r_cnt}) + 1 >= TIMEOUT_CYCLES;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_load_data <= '0;
            r_we        <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.mem_valid) begin
                    if (bus.mem_addr[1:0] == 2'b00) begin
                        r_addr  <= bus.mem_addr;
                        r_wdata <= bus.mem_wdata;
                        r_we    <= bus.mem_we;
                        r_cnt   <= '0;
                        r_state <= WAIT;
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                WAIT: if (bus.core_grant) begin
                    if (!r_we) r_load_data <= bus.core_rdata;
                    r_cnt   <= '0;
                    r_state <= RESP;
                end else if (w_timeout) begin
                    r_err       <= 1'b1;
                    r_load_data <= '0;
                    r_cnt       <= '0;
                    r_state     <= RESP;
                end else if (r_cnt != 16'hFFFF) begin
                    r_cnt <= r_cnt + 16'd1;
                end
                default: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end
    assign bus.stall         = w_wait || (r_state == IDLE && bus.mem_valid);
    assign bus.done          = r_state == RESP;
    assign bus.err           = r_err;
    assign bus.load_data     = r_load_data;
    assign bus.core_req      = w_wait;
    assign bus.core_addr     = w_wait ? r_addr : '0;
    assign bus.core_wdata    = w_wait ? r_wdata : '0;
    assign bus.core_memwrite = w_wait && r_we;
    assign bus.core_memread  = w_wait && !r_we;
endmodule
